// File: rtl/pokey_pkg.sv
// Shared POKEY definitions used by the serial-output controller.
package pokey_pkg;

    // Shifter FSM states of the serial-output path.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } sdo_state_t;

    // Idle/mark level of the serial line.
    localparam logic SDO_MARK      = 1'b1;

    // Number of data bits in one serial frame.
    localparam int   SDO_DATA_BITS = 8;

    // Line level presented by the shifter for a given state and LSB.
    function automatic logic sdo_line(input sdo_state_t st, input logic lsb);
        logic lvl;
        lvl = SDO_MARK;
        case (st)
            START:   lvl = 1'b0;
            DATA:    lvl = lsb;
            default: lvl = SDO_MARK;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/sdo_ctrl_if.sv
// Register-side and IRQ-side signals of the serial-output controller.
interface sdo_ctrl_if;
    logic       serWr;
    logic [7:0] Dw;
    logic       sioTick;
    logic       forceBreak;
    logic       sdo;
    logic       setSdoCompl;
    logic       sdoFinish;

    // Controller side.
    modport slave (
        input  serWr, Dw, sioTick, forceBreak,
        output sdo, setSdoCompl, sdoFinish
    );

    // Register-decode / IRQ-core side.
    modport master (
        output serWr, Dw, sioTick, forceBreak,
        input  sdo, setSdoCompl, sdoFinish
    );
endinterface

// File: rtl/sdo_bit_timer.sv
// Serial bit timer: counts serial-clock ticks and flags the tick that
// closes the current bit. Held at zero while clr is asserted so ticks
// seen in IDLE or on the transfer cycle never count toward a bit.
module sdo_bit_timer #(
    parameter int BIT_TICKS = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic enp,
    input  logic clr,
    input  logic tick,
    output logic bitEnd
);

    localparam logic [7:0] LAST_TICK = 8'(BIT_TICKS - 1);

    logic [7:0] tickCnt_q;
    logic [7:0] tickCnt_d;
    logic       atLast;

    assign atLast = (tickCnt_q == LAST_TICK);
    assign bitEnd = enp && !clr && tick && atLast;

    // Next tick count: clear, wrap at the last tick of a bit, or advance.
    always_comb begin
        tickCnt_d = tickCnt_q;
        if (enp) begin
            if (clr) begin
                tickCnt_d = 8'd0;
            end else if (tick) begin
                tickCnt_d = atLast ? 8'd0 : tickCnt_q + 8'd1;
            end
        end
    end

    // Tick counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            tickCnt_q <= 8'd0;
        end else begin
            tickCnt_q <= tickCnt_d;
        end
    end

endmodule

// File: rtl/sdo_ctrl.sv
// POKEY serial-output controller: SEROUT holding register, start/8N/stop
// framing onto the serial line, and the data-needed / finished IRQ sources.
module sdo_ctrl
    import pokey_pkg::*;
#(
    parameter int BIT_TICKS = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enp,
    sdo_ctrl_if.slave  bus
);

    sdo_state_t state_q, state_d;
    logic       holdFull_q, holdFull_d;
    logic [7:0] hold_q, hold_d;
    logic [7:0] shreg_q, shreg_d;
    logic [2:0] bitCnt_q, bitCnt_d;
    logic       setSdoCompl_q, setSdoCompl_d;
    logic       sdoFinish_q, sdoFinish_d;
    logic       timerClr;
    logic       bitEnd;

    // The timer is parked while idle; this also discards a tick that
    // coincides with the hold-to-shifter transfer.
    assign timerClr = (state_q == IDLE);

    sdo_bit_timer #(
        .BIT_TICKS (BIT_TICKS)
    ) u_bit_timer (
        .clk    (clk),
        .reset  (reset),
        .enp    (enp),
        .clr    (timerClr),
        .tick   (bus.sioTick),
        .bitEnd (bitEnd)
    );

    // Next-state logic for the shifter FSM, holding register and IRQ sources.
    always_comb begin
        state_d       = state_q;
        holdFull_d    = holdFull_q;
        hold_d        = hold_q;
        shreg_d       = shreg_q;
        bitCnt_d      = bitCnt_q;
        setSdoCompl_d = setSdoCompl_q;
        sdoFinish_d   = sdoFinish_q;

        if (enp) begin
            setSdoCompl_d = 1'b0;

            case (state_q)
                IDLE: begin
                    // Transfer looks only at the registered flag, so a write
                    // landing on the STOP->IDLE cycle starts one cycle later.
                    if (holdFull_q) begin
                        state_d       = START;
                        shreg_d       = hold_q;
                        holdFull_d    = 1'b0;
                        setSdoCompl_d = 1'b1;
                    end
                end
                START: begin
                    if (bitEnd) begin
                        state_d  = DATA;
                        bitCnt_d = 3'd0;
                    end
                end
                DATA: begin
                    if (bitEnd) begin
                        shreg_d = shreg_q >> 1;
                        if (bitCnt_q == 3'(SDO_DATA_BITS - 1)) begin
                            state_d = STOP;
                        end else begin
                            bitCnt_d = bitCnt_q + 3'd1;
                        end
                    end
                end
                STOP: begin
                    if (bitEnd) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase

            // A write always lands in the holding register; the byte being
            // transferred this cycle was already taken from hold_q above.
            if (bus.serWr) begin
                hold_d     = bus.Dw;
                holdFull_d = 1'b1;
            end

            sdoFinish_d = !((state_d == IDLE) && !holdFull_d);
        end
    end

    // Control registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            holdFull_q    <= 1'b0;
            bitCnt_q      <= 3'd0;
            setSdoCompl_q <= 1'b0;
            sdoFinish_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            holdFull_q    <= holdFull_d;
            bitCnt_q      <= bitCnt_d;
            setSdoCompl_q <= setSdoCompl_d;
            sdoFinish_q   <= sdoFinish_d;
        end
    end

    // Data registers; their contents only matter when qualified by holdFull/state.
    always_ff @(posedge clk) begin
        hold_q  <= hold_d;
        shreg_q <= shreg_d;
    end

    // Break forces a space on the line without disturbing the shifter.
    assign bus.sdo         = bus.forceBreak ? 1'b0 : sdo_line(state_q, shreg_q[0]);
    assign bus.setSdoCompl = setSdoCompl_q;
    assign bus.sdoFinish   = sdoFinish_q;

endmodule

// File: tb/tb_sdo_ctrl.sv
// Randomized scoreboard bench for sdo_ctrl with a frame-level reference model.
module tb_sdo_ctrl;

    localparam int BT = 2;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic enp   = 1'b0;

    sdo_ctrl_if bus();

    sdo_ctrl #(.BIT_TICKS(BT)) dut (
        .clk   (clk),
        .reset (reset),
        .enp   (enp),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         wr_cyc;
        bit         from_idle;
    } exp_t;

    exp_t exp_q[$];
    bit   hold_pending = 1'b0;
    int   cyc          = 0;
    int   n_chk        = 0;
    int   n_pass       = 0;
    int   pulses       = 0;
    bit   mon_inframe  = 1'b0;
    int   mon_bit      = 0;

    task automatic chk(input string name, input int act, input int req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (enp cycle %0d)", name, act, req, cyc);
    endtask

    task automatic fail(input string name);
        n_chk++;
        $display("FAIL %s: bound expired (enp cycle %0d)", name, cyc);
    endtask

    // Reference model of the SEROUT holding register: one pending byte, overwritten while pending.
    task automatic model_write(input logic [7:0] d);
        if (hold_pending) begin
            exp_q[exp_q.size()-1].data = d;
        end else begin
            exp_q.push_back('{data: d, wr_cyc: cyc, from_idle: !mon_inframe});
            hold_pending = 1'b1;
        end
    endtask

    // One enp period (4 clk); sioTick on every 4th enp cycle.
    task automatic enp_cycle(input bit wr = 1'b0, input logic [7:0] d = 8'h00);
        @(negedge clk);
        enp       = 1'b0;
        bus.serWr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        cyc++;
        enp         = 1'b1;
        bus.sioTick = ((cyc % 4) == 0);
        bus.serWr   = wr;
        bus.Dw      = d;
        if (wr) model_write(d);
    endtask

    task automatic wait_bit(input int k);
        int n;
        n = 0;
        while (!(mon_inframe && mon_bit == k) && n < 400) begin
            enp_cycle();
            n++;
        end
        if (n >= 400) fail("wait_bit");
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((mon_inframe || exp_q.size() != 0) && n < 600) begin
            enp_cycle();
            n++;
        end
        if (n >= 600) fail("wait_idle");
        repeat (3) enp_cycle();
    endtask

    task automatic do_reset();
        @(negedge clk);
        enp       = 1'b0;
        bus.serWr = 1'b0;
        reset     = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_sdo",         int'(bus.sdo),         1);
        chk("rst_setSdoCompl", int'(bus.setSdoCompl), 0);
        chk("rst_sdoFinish",   int'(bus.sdoFinish),   0);
        exp_q.delete();
        hold_pending = 1'b0;
        reset        = 1'b0;
    endtask

    // Monitor: follows each frame by counting ticks and compares the line bit by bit.
    initial begin
        exp_t       cur;
        logic [9:0] frame;
        int         tcnt;
        int         idle_wait;
        frame     = '1;
        tcnt      = 0;
        idle_wait = 0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                mon_inframe = 1'b0;
                idle_wait   = 0;
                continue;
            end
            if (!enp) continue;
            if (!mon_inframe) begin
                if (bus.setSdoCompl) begin
                    pulses++;
                    if (exp_q.size() == 0) begin
                        chk("compl_when_empty", int'(bus.setSdoCompl), 0);
                    end else begin
                        cur          = exp_q.pop_front();
                        hold_pending = 1'b0;
                        if (cur.from_idle) chk("compl_latency", cyc, cur.wr_cyc + 1);
                        frame       = {1'b1, cur.data, 1'b0};
                        mon_inframe = 1'b1;
                        mon_bit     = 0;
                        tcnt        = 0;
                        idle_wait   = 0;
                        chk("start_bit", int'(bus.sdo), 0);
                        chk("start_finish", int'(bus.sdoFinish), 1);
                    end
                end else begin
                    chk("idle_sdo",    int'(bus.sdo),       int'(!bus.forceBreak));
                    chk("idle_finish", int'(bus.sdoFinish), int'(exp_q.size() != 0));
                    if (exp_q.size() != 0) begin
                        idle_wait++;
                        if (idle_wait > 2) begin
                            chk("compl_timeout", int'(bus.setSdoCompl), 1);
                            void'(exp_q.pop_front());
                            hold_pending = 1'b0;
                            idle_wait    = 0;
                        end
                    end else begin
                        idle_wait = 0;
                    end
                end
            end else begin
                if (bus.sioTick) tcnt++;
                if (tcnt == BT) begin
                    tcnt = 0;
                    mon_bit++;
                end
                if (mon_bit == 10) begin
                    mon_inframe = 1'b0;
                    chk("finish_after_stop", int'(bus.sdoFinish), int'(exp_q.size() != 0));
                    chk("mark_after_stop",   int'(bus.sdo),       int'(!bus.forceBreak));
                end else begin
                    chk("frame_bit", int'(bus.sdo), bus.forceBreak ? 0 : int'(frame[mon_bit]));
                    chk("frame_ctl", int'({bus.setSdoCompl, bus.sdoFinish}), 1);
                end
            end
        end
    end

    // Stimulus.
    initial begin
        int p0;
        int k;
        bus.serWr      = 1'b0;
        bus.Dw         = 8'h00;
        bus.sioTick    = 1'b0;
        bus.forceBreak = 1'b0;

        do_reset();
        repeat (4) enp_cycle();

        // Single byte.
        enp_cycle(1'b1, 8'hA5);
        wait_idle();

        // Back-to-back: second byte held during the first frame's data bits.
        enp_cycle(1'b1, 8'h00);
        wait_bit(4);
        enp_cycle(1'b1, 8'hFF);
        wait_idle();

        // Overwrite of a held byte: only the last write is sent.
        p0 = pulses;
        enp_cycle(1'b1, 8'h11);
        wait_bit(3);
        enp_cycle(1'b1, 8'h33);
        wait_bit(5);
        enp_cycle(1'b1, 8'h22);
        wait_idle();
        chk("overwrite_pulses", pulses - p0, 2);

        // Force break in the middle of a frame.
        enp_cycle(1'b1, 8'h55);
        wait_bit(3);
        bus.forceBreak = 1'b1;
        wait_bit(6);
        bus.forceBreak = 1'b0;
        wait_idle();

        // Randomized frames, held bytes, overwrites and breaks.
        for (int i = 0; i < 16; i++) begin
            enp_cycle(1'b1, 8'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                k = $urandom_range(2, 4);
                wait_bit(k);
                enp_cycle(1'b1, 8'($urandom));
                if ($urandom_range(0, 1) == 1) begin
                    wait_bit(k + 2);
                    enp_cycle(1'b1, 8'($urandom));
                end
            end
            if ($urandom_range(0, 3) == 0) begin
                wait_bit(7);
                bus.forceBreak = 1'b1;
                wait_bit(8);
                bus.forceBreak = 1'b0;
            end
            wait_idle();
            repeat ($urandom_range(0, 5)) enp_cycle();
        end

        // Reset mid-frame with a byte held: frame aborted, held byte dropped.
        enp_cycle(1'b1, 8'h3C);
        wait_bit(3);
        enp_cycle(1'b1, 8'hC3);
        wait_bit(5);
        p0 = pulses;
        do_reset();
        repeat (150) enp_cycle();
        chk("no_compl_after_reset", pulses, p0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // Watchdog.
    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
